// File: rtl/wb_pwm_array.sv
// Wishbone-classic register block driving NCH PWM channels. Period and duty are
// written to shadows and load into the active set only on counter wrap.

module wb_pwm_chan #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          pol,
    input  logic          per_wr,
    input  logic          duty_wr,
    input  logic [31:0]   wdat,
    input  logic [31:0]   wbe,
    output logic [CW-1:0] per_sh,
    output logic [CW-1:0] duty_sh,
    output logic          pwm,
    output logic          wrap
);
    logic [CW-1:0] per_act, duty_act, cnt;

    function automatic logic [CW-1:0] merge(input logic [CW-1:0] old, input logic [31:0] d,
                                            input logic [31:0] be);
        return CW'((32'(old) & ~be) | (d & be));
    endfunction

    assign wrap = en && (cnt == per_act);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_sh   <= '0;
            duty_sh  <= '0;
            per_act  <= '0;
            duty_act <= '0;
            cnt      <= '0;
            pwm      <= 1'b0;
        end else begin
            if (per_wr)  per_sh  <= merge(per_sh, wdat, wbe);
            if (duty_wr) duty_sh <= merge(duty_sh, wdat, wbe);
            if (!en) begin
                // idle tracks the shadows so a fresh enable starts with current values
                cnt      <= '0;
                per_act  <= per_sh;
                duty_act <= duty_sh;
                pwm      <= pol;
            end else begin
                pwm <= (cnt < duty_act) ^ pol;
                if (wrap) begin
                    cnt      <= '0;
                    per_act  <= per_sh;
                    duty_act <= duty_sh;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end
endmodule

module wb_pwm_array #(
    parameter int          NCH    = 4,
    parameter int          CW     = 16,
    parameter logic [19:0] ADR_HI = 20'h30001
) (
    input  logic           wb_clk_i,
    input  logic           wb_rst_ni,
    input  logic           wbs_stb_i,
    input  logic           wbs_cyc_i,
    input  logic           wbs_we_i,
    input  logic [3:0]     wbs_sel_i,
    input  logic [31:0]    wbs_adr_i,
    input  logic [31:0]    wbs_dat_i,
    output logic           wbs_ack_o,
    output logic [31:0]    wbs_dat_o,
    output logic [NCH-1:0] pwm_o,
    output logic           irq_o
);
    typedef struct packed {
        logic        we;
        logic [5:0]  widx;
        logic [3:0]  sel;
        logic [31:0] dat;
    } wb_req_t;

    wb_req_t                  req;
    logic                     acc, wr, unused_adr;
    logic [31:0]              wbe, rdata, ctrl32;
    logic [NCH-1:0]           en, pol, status, mask, wrap, per_wr, duty_wr, w1c;
    logic [NCH-1:0][CW-1:0]   per_sh, duty_sh;

    function automatic logic [31:0] bmerge(input logic [31:0] old, input logic [31:0] d,
                                           input logic [31:0] be);
        return (old & ~be) | (d & be);
    endfunction

    assign req        = '{we: wbs_we_i, widx: wbs_adr_i[7:2], sel: wbs_sel_i, dat: wbs_dat_i};
    assign unused_adr = ^{wbs_adr_i[11:8], wbs_adr_i[1:0]};
    // ack high blocks a second access so a held strobe is acked every other cycle
    assign acc    = wbs_stb_i && wbs_cyc_i && (wbs_adr_i[31:12] == ADR_HI) && !wbs_ack_o;
    assign wr     = acc && req.we;
    assign wbe    = {{8{req.sel[3]}}, {8{req.sel[2]}}, {8{req.sel[1]}}, {8{req.sel[0]}}};
    assign ctrl32 = 32'(en) | (32'(pol) << 8);
    assign w1c    = (wr && req.widx == 6'd1) ? NCH'(req.dat & wbe) : '0;

    for (genvar n = 0; n < NCH; n++) begin : g_ch
        assign per_wr[n]  = wr && (req.widx == 6'(4 + 2*n));
        assign duty_wr[n] = wr && (req.widx == 6'(5 + 2*n));
        wb_pwm_chan #(.CW(CW)) u_ch (
            .clk     (wb_clk_i),
            .rst_n   (wb_rst_ni),
            .en      (en[n]),
            .pol     (pol[n]),
            .per_wr  (per_wr[n]),
            .duty_wr (duty_wr[n]),
            .wdat    (req.dat),
            .wbe     (wbe),
            .per_sh  (per_sh[n]),
            .duty_sh (duty_sh[n]),
            .pwm     (pwm_o[n]),
            .wrap    (wrap[n])
        );
    end

    always_comb begin
        rdata = '0;
        case (req.widx)
            6'd0:    rdata = ctrl32;
            6'd1:    rdata = 32'(status);
            6'd2:    rdata = 32'(mask);
            default: begin
                for (int n = 0; n < NCH; n++) begin
                    if (req.widx == 6'(4 + 2*n)) rdata = 32'(per_sh[n]);
                    if (req.widx == 6'(5 + 2*n)) rdata = 32'(duty_sh[n]);
                end
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            en        <= '0;
            pol       <= '0;
            status    <= '0;
            mask      <= '0;
            irq_o     <= 1'b0;
        end else begin
            wbs_ack_o <= acc;
            wbs_dat_o <= acc ? rdata : '0;
            // a wrap in the same cycle as a clear keeps the flag set
            status    <= (status & ~w1c) | wrap;
            irq_o     <= |(status & mask);
            if (wr && req.widx == 6'd0) begin
                en  <= NCH'(bmerge(ctrl32, req.dat, wbe));
                pol <= NCH'(bmerge(ctrl32, req.dat, wbe) >> 8);
            end
            if (wr && req.widx == 6'd2) mask <= NCH'(bmerge(32'(mask), req.dat, wbe));
        end
    end
endmodule

// File: tb/tb_wb_pwm_array.sv
// Scoreboard bench for wb_pwm_array: stimulus queues expected read data and
// pwm/irq observations; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_wb_pwm_array;
    localparam int          NCH = 4;
    localparam int          CW  = 16;
    localparam logic [19:0] HI  = 20'h30001;

    logic           clk = 1'b0, rst_n = 1'b0;
    logic           stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]     sel = '0;
    logic [31:0]    adr = '0, dat = '0;
    logic           ack, irq;
    logic [31:0]    dat_o;
    logic [NCH-1:0] pwm;
    logic           obs_req = 1'b0;

    typedef struct {
        string       name;
        logic [31:0] exp;
        logic        kind;   // 0: pwm_o[0], 1: irq_o
    } exp_t;

    exp_t rd_q[$];
    exp_t obs_q[$];
    int   checks = 0, errors = 0, ack_cnt = 0;

    wb_pwm_array #(.NCH(NCH), .CW(CW), .ADR_HI(HI)) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .wbs_stb_i (stb),
        .wbs_cyc_i (cyc),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (dat),
        .wbs_ack_o (ack),
        .wbs_dat_o (dat_o),
        .pwm_o     (pwm),
        .irq_o     (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && !ack) chk("dat_when_no_ack", dat_o, 32'h0);
        if (ack) begin
            ack_cnt++;
            if (!we) begin
                if (rd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ack: got ack with data %0h expected none", dat_o);
                end else begin
                    e = rd_q.pop_front();
                    chk(e.name, dat_o, e.exp);
                end
            end
        end
        if (obs_req) begin
            if (obs_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL obs_underflow: got request expected queued value");
            end else begin
                e = obs_q.pop_front();
                chk(e.name, e.kind ? 32'(irq) : 32'(pwm[0]), e.exp);
            end
        end
    end

    task automatic bus(input logic w, input logic [7:0] off, input logic [31:0] d,
                       input logic [3:0] s, output int lat);
        adr = {HI, 4'h0, off}; we = w; dat = d; sel = s; stb = 1'b1; cyc = 1'b1; lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!ack && lat < 8);
        stb = 1'b0; cyc = 1'b0;
        if (!ack) begin
            checks++; errors++;
            $display("FAIL bus_timeout: off %0h got no ack expected ack", off);
        end
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s = 4'hF);
        int l;
        bus(1'b1, off, d, s, l);
    endtask

    task automatic rd(input string nm, input logic [7:0] off, input logic [31:0] exp);
        int l;
        rd_q.push_back('{nm, exp, 1'b0});
        bus(1'b0, off, 32'h0, 4'hF, l);
        chk({nm, "_latency"}, 32'(l), 32'd1);
    endtask

    task automatic obs(input string nm, input logic k, input logic [31:0] e);
        obs_q.push_back('{nm, e, k});
        obs_req = 1'b1;
        @(posedge clk); #1;
        obs_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        int a0;
        idle(2);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_dat", dat_o, 32'h0);
        chk("rst_pwm", 32'(pwm), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        rst_n = 1'b1;
        idle(1);

        rd("rd_ctrl", 8'h00, 32'h0);
        rd("rd_status", 8'h04, 32'h0);
        rd("rd_period0", 8'h10, 32'h0);
        chk("idle_pwm", 32'(pwm), 32'h0);

        // byte enables, upper bytes beyond CW ignored
        wr(8'h18, 32'hAABBCCDD, 4'b0001);
        rd("be_byte0", 8'h18, 32'h0000_00DD);
        wr(8'h18, 32'h11223344, 4'b1110);
        rd("be_upper", 8'h18, 32'h0000_33DD);

        // period 10, duty 3
        wr(8'h10, 32'd9);
        wr(8'h14, 32'd3);
        rd("shadow_period0", 8'h10, 32'd9);
        rd("shadow_duty0", 8'h14, 32'd3);
        wr(8'h00, 32'h1);
        for (int k = 0; k < 20; k++) obs("pwm_duty3", 1'b0, 32'((k % 10) < 3));
        rd("status_wrap", 8'h04, 32'h1);

        // duty change mid-period lands at the next wrap
        wr(8'h14, 32'd7);
        for (int j = 26; j < 52; j++) obs("pwm_duty7", 1'b0, (j < 32) ? 32'h0 : 32'((j - 32) % 10 < 7));

        // irq from masked wrap, clear, and set-wins on coincident clear
        wr(8'h04, 32'h1);
        wr(8'h08, 32'h1);
        for (int j = 56; j < 64; j++) obs("irq_wrap", 1'b1, 32'(j >= 62));
        wr(8'h04, 32'h1);
        obs("irq_clear", 1'b1, 32'h0);
        idle(3);
        wr(8'h04, 32'h1);
        obs("irq_set_wins", 1'b1, 32'h1);
        rd("status_set_wins", 8'h04, 32'h1);

        // inverted polarity with duty 0 -> constantly high
        wr(8'h00, 32'h0);
        wr(8'h14, 32'd0);
        wr(8'h00, 32'h101);
        for (int k = 0; k < 12; k++) obs("pwm_inv_duty0", 1'b0, 32'h1);

        // duty above period -> constantly active
        wr(8'h00, 32'h0);
        wr(8'h14, 32'd20);
        wr(8'h00, 32'h1);
        for (int k = 0; k < 12; k++) obs("pwm_duty_gt_period", 1'b0, 32'h1);

        // idle output follows polarity
        wr(8'h00, 32'h0);
        obs("idle_pol0", 1'b0, 32'h0);
        wr(8'h00, 32'h100);
        obs("idle_pol1", 1'b0, 32'h1);

        // period 0 wraps every cycle
        wr(8'h00, 32'h0);
        wr(8'h10, 32'd0);
        wr(8'h14, 32'd1);
        wr(8'h04, 32'h1);
        wr(8'h00, 32'h1);
        for (int k = 0; k < 5; k++) obs("pwm_period0", 1'b0, 32'h1);
        wr(8'h04, 32'h1);
        rd("status_period0", 8'h04, 32'h1);

        // held strobe on a foreign block never acks
        a0 = ack_cnt;
        adr = {20'h30002, 12'h000}; we = 1'b0; stb = 1'b1; cyc = 1'b1;
        idle(5);
        stb = 1'b0; cyc = 1'b0;
        chk("unselected_no_ack", 32'(ack_cnt - a0), 32'h0);

        // held strobe on this block acks every other cycle
        a0 = ack_cnt;
        rd_q.push_back('{"held_read_a", 32'h1, 1'b0});
        rd_q.push_back('{"held_read_b", 32'h1, 1'b0});
        adr = {HI, 12'h008}; we = 1'b0; stb = 1'b1; cyc = 1'b1;
        idle(4);
        stb = 1'b0; cyc = 1'b0;
        idle(1);
        chk("held_strobe_acks", 32'(ack_cnt - a0), 32'd2);

        // channel beyond NCH and unmapped offset
        wr(8'h40, 32'hFFFF_FFFF);
        rd("ch6_readback", 8'h40, 32'h0);
        wr(8'h0C, 32'hFFFF_FFFF);
        rd("unmapped_readback", 8'h0C, 32'h0);

        // reset in the middle of an access and a running period
        a0 = ack_cnt;
        adr = {HI, 12'h000}; we = 1'b0; stb = 1'b1; cyc = 1'b1;
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_ack", 32'(ack), 32'h0);
        chk("rst_mid_pwm", 32'(pwm), 32'h0);
        chk("rst_mid_irq", 32'(irq), 32'h0);
        stb = 1'b0; cyc = 1'b0;
        idle(1);
        chk("rst_mid_no_ack", 32'(ack_cnt - a0), 32'h0);
        rst_n = 1'b1;
        idle(1);
        rd("rst_ctrl", 8'h00, 32'h0);
        rd("rst_mask", 8'h08, 32'h0);
        rd("rst_duty0", 8'h14, 32'h0);
        chk("rst_resume_pwm", 32'(pwm), 32'h0);

        idle(3);
        chk("rd_queue_drained", 32'(rd_q.size()), 32'h0);
        chk("obs_queue_drained", 32'(obs_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
